// File: rtl/vec3_alu_pipe_pkg.sv
// Shared types for the vec3 fixed-point ALU pipeline.
// Opcode enum and opcode count.
package vec3_alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_NEG   = 3'd2,
    OP_DOT   = 3'd3,
    OP_CROSS = 3'd4,
    OP_SCALE = 3'd5,
    OP_MUL   = 3'd6,
    OP_RSVD  = 3'd7
  } vec3_op_e;

  localparam int OP_COUNT = 7;

endpackage

// File: rtl/vec3_alu_pipe_if.sv
// Valid/ready bundle between march sequencer and vec3 ALU.
// master: op source / result sink; slave: the ALU.
interface vec3_alu_pipe_if
  import vec3_alu_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  vec3_op_e         in_op;
  logic [3*W-1:0]   in_a;
  logic [3*W-1:0]   in_b;
  logic [W-1:0]     in_s;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3*W-1:0]   out_res;
  logic             out_ovf;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_s, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_ovf, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_s, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_ovf, out_err, out_tag
  );
endinterface

// File: rtl/vec3_lane_narrow.sv
// Narrows a (W+2)-bit lane to W bits, saturating or wrapping.
// d: wide lane, q: narrowed lane, ovf: d outside W-bit range.
module vec3_lane_narrow #(
  parameter int W   = 32,
  parameter int SAT = 1
) (
  input  logic signed [W+1:0] d,
  output logic        [W-1:0] q,
  output logic                ovf
);
  assign ovf = d[W+1:W-1] != {3{d[W-1]}};

  always_comb begin
    q = d[W-1:0];
    if (SAT != 0 && ovf) begin
      q = d[W+1] ? {1'b1, {(W-1){1'b0}}}
                 : {1'b0, {(W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/vec3_alu_pipe.sv
// Two-stage pipelined fixed-point vec3 ALU with valid/ready flow.
// clk, rst_n (async low), bus: slave side of vec3_alu_pipe_if.
module vec3_alu_pipe
  import vec3_alu_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int SAT   = 1,
  parameter int TAG_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  vec3_alu_pipe_if.slave bus
);
  localparam int PW = 2 * W;
  localparam int NW = W + 2;

  logic signed [W-1:0]  la [3];
  logic signed [W-1:0]  lb [3];
  logic signed [W-1:0]  ma [6];
  logic signed [W-1:0]  mb [6];
  logic signed [PW-1:0] prod [6];
  logic signed [W:0]    sum [3];

  logic                 s1_valid;
  vec3_op_e             s1_op;
  logic [TAG_W-1:0]     s1_tag;
  logic signed [PW-1:0] s1_p [6];
  logic signed [W:0]    s1_sum [3];

  logic signed [PW+1:0] sh [6];
  logic signed [PW+1:0] wide [3];
  logic signed [NW-1:0] nar [3];
  logic [W-1:0]         q [3];
  logic [2:0]           lov;
  logic                 rsvd;

  logic                 o_valid;
  logic [3*W-1:0]       o_res;
  logic                 o_ovf;
  logic                 o_err;
  logic [TAG_W-1:0]     o_tag;
  logic                 advance;
  logic                 in_ready;

  assign advance  = !o_valid || bus.out_ready;
  assign in_ready = !s1_valid || advance;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      la[i] = bus.in_a[i*W +: W];
      lb[i] = bus.in_b[i*W +: W];
    end
  end

  // Six shared multipliers; CROSS and SCALE only re-steer inputs.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ma[i] = la[i];
      mb[i] = lb[i];
    end
    ma[3] = la[2]; mb[3] = lb[1];
    ma[4] = la[0]; mb[4] = lb[2];
    ma[5] = la[1]; mb[5] = lb[0];
    unique case (1'b1)
      bus.in_op == OP_CROSS: begin
        ma[0] = la[1]; mb[0] = lb[2];
        ma[1] = la[2]; mb[1] = lb[0];
        ma[2] = la[0]; mb[2] = lb[1];
      end
      bus.in_op == OP_SCALE: begin
        for (int i = 0; i < 3; i++) mb[i] = bus.in_s;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 6; i++)
      prod[i] = PW'(ma[i]) * PW'(mb[i]);
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum[i] = '0;
      unique case (1'b1)
        bus.in_op == OP_ADD:
          sum[i] = (W+1)'(la[i]) + (W+1)'(lb[i]);
        bus.in_op == OP_SUB:
          sum[i] = (W+1)'(la[i]) - (W+1)'(lb[i]);
        bus.in_op == OP_NEG:
          sum[i] = -((W+1)'(la[i]));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_tag   <= '0;
      for (int i = 0; i < 6; i++) s1_p[i] <= '0;
      for (int i = 0; i < 3; i++) s1_sum[i] <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op  <= bus.in_op;
        s1_tag <= bus.in_tag;
        for (int i = 0; i < 6; i++) s1_p[i] <= prod[i];
        for (int i = 0; i < 3; i++) s1_sum[i] <= sum[i];
      end
    end
  end

  // Exact result is formed at PW+2 bits, then folded to NW bits:
  // out-of-range values keep their low W bits (for wrap) and get
  // top bits that stay outside the W-bit range on the correct side.
  function automatic logic signed [NW-1:0] fold(
    input logic signed [PW+1:0] x
  );
    if (x[PW+1:NW-1] == {(PW+3-NW){x[PW+1]}})
      return x[NW-1:0];
    return {x[PW+1], ~x[PW+1], x[W-1:0]};
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++)
      sh[i] = (PW+2)'(s1_p[i] >>> FRAC);
  end

  always_comb begin
    for (int i = 0; i < 3; i++) wide[i] = '0;
    unique case (1'b1)
      s1_op inside {OP_ADD, OP_SUB, OP_NEG}: begin
        for (int i = 0; i < 3; i++)
          wide[i] = (PW+2)'(s1_sum[i]);
      end
      s1_op == OP_DOT:
        wide[0] = sh[0] + sh[1] + sh[2];
      s1_op == OP_CROSS: begin
        for (int i = 0; i < 3; i++)
          wide[i] = sh[i] - sh[i+3];
      end
      s1_op inside {OP_SCALE, OP_MUL}: begin
        for (int i = 0; i < 3; i++) wide[i] = sh[i];
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) nar[i] = fold(wide[i]);
  end

  assign rsvd = int'(s1_op) >= OP_COUNT;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    vec3_lane_narrow #(
      .W   (W),
      .SAT (SAT)
    ) u_narrow (
      .d   (nar[g]),
      .q   (q[g]),
      .ovf (lov[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_res   <= '0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
      o_tag   <= '0;
    end else if (advance) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_res <= {q[2], q[1], q[0]};
        o_ovf <= |lov;
        o_err <= rsvd;
        o_tag <= s1_tag;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = o_valid;
  assign bus.out_res   = o_res;
  assign bus.out_ovf   = o_ovf;
  assign bus.out_err   = o_err;
  assign bus.out_tag   = o_tag;
endmodule

// File: tb/tb_vec3_alu_pipe.sv
// Directed bench for vec3_alu_pipe (W=32, FRAC=16).
// Drives a SAT=1 and a SAT=0 instance with identical stimulus.
module tb_vec3_alu_pipe;
  import vec3_alu_pipe_pkg::*;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  vec3_alu_pipe_if #(.W(32), .TAG_W(8)) i1 ();
  vec3_alu_pipe_if #(.W(32), .TAG_W(8)) i0 ();

  vec3_alu_pipe #(.W(32), .FRAC(16), .SAT(1), .TAG_W(8)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i1)
  );

  vec3_alu_pipe #(.W(32), .FRAC(16), .SAT(0), .TAG_W(8)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i0)
  );

  function automatic logic [95:0] v3(
    input logic [31:0] x, input logic [31:0] y, input logic [31:0] z
  );
    return {z, y, x};
  endfunction

  task automatic chk(
    input string nm, input logic [95:0] got, input logic [95:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_out(
    input string nm, input logic [95:0] res, input logic ovf,
    input logic err, input logic [7:0] tag
  );
    chk({nm, ".valid"}, 96'(i1.out_valid), 96'(1'b1));
    chk({nm, ".res"}, i1.out_res, res);
    chk({nm, ".ovf"}, 96'(i1.out_ovf), 96'(ovf));
    chk({nm, ".err"}, 96'(i1.out_err), 96'(err));
    chk({nm, ".tag"}, 96'(i1.out_tag), 96'(tag));
  endtask

  task automatic drive(
    input vec3_op_e op, input logic [95:0] a, input logic [95:0] b,
    input logic [31:0] s, input logic [7:0] tag
  );
    i1.in_valid = 1'b1; i0.in_valid = 1'b1;
    i1.in_op = op;      i0.in_op = op;
    i1.in_a = a;        i0.in_a = a;
    i1.in_b = b;        i0.in_b = b;
    i1.in_s = s;        i0.in_s = s;
    i1.in_tag = tag;    i0.in_tag = tag;
  endtask

  task automatic idle();
    i1.in_valid = 1'b0;
    i0.in_valid = 1'b0;
  endtask

  task automatic set_ordy(input logic r);
    i1.out_ready = r;
    i0.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int k;
  int r;
  int nfire;
  logic acc;
  logic fire;

  initial begin
    drive(OP_ADD, '0, '0, '0, '0);
    idle();
    set_ordy(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 96'(i1.out_valid), 96'(1'b0));
    chk("rst.res", i1.out_res, '0);
    chk("rst.tag", 96'(i1.out_tag), '0);
    chk("rst.ovf", 96'({i1.out_ovf, i1.out_err}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 96'(i1.in_ready), 96'(1'b1));

    // DOT with latency check
    drive(OP_DOT, v3(ONE, 2*ONE, 3*ONE), v3(4*ONE, 5*ONE, 6*ONE), '0, 8'h01);
    #1;
    chk("dot.rdy", 96'(i1.in_ready), 96'(1'b1));
    tick();
    idle();
    chk("dot.lat", 96'(i1.out_valid), 96'(1'b0));
    tick();
    chk_out("dot", v3(32'h0020_0000, 0, 0), 1'b0, 1'b0, 8'h01);

    // CROSS then SCALE back-to-back
    drive(OP_CROSS, v3(ONE, 0, 0), v3(0, ONE, 0), '0, 8'h02);
    tick();
    drive(OP_SCALE, v3(32'h0000_8000, 32'hFFFE_0000, 3*ONE), '0,
          32'hFFFE_0000, 8'h03);
    tick();
    idle();
    chk_out("cross", v3(0, 0, ONE), 1'b0, 1'b0, 8'h02);
    tick();
    chk_out("scale", v3(32'hFFFF_0000, 32'h0004_0000, 32'hFFFA_0000),
            1'b0, 1'b0, 8'h03);

    // ADD overflow: saturate vs wrap
    drive(OP_ADD, v3(32'h7FFF_0000, 0, 0), v3(32'h0002_0000, 0, 0), '0, 8'h04);
    tick();
    idle();
    tick();
    chk_out("add_sat", v3(32'h7FFF_FFFF, 0, 0), 1'b1, 1'b0, 8'h04);
    chk("add_wrap.res", i0.out_res, v3(32'h8001_0000, 0, 0));
    chk("add_wrap.ovf", 96'(i0.out_ovf), 96'(1'b1));

    // MUL, SUB, NEG of most negative
    drive(OP_MUL, v3(32'h0001_8000, 32'hFFFE_0000, 32'h0000_4000),
          v3(2*ONE, 3*ONE, 32'hFFFC_0000), '0, 8'h05);
    tick();
    drive(OP_SUB, v3(ONE, ONE, ONE), v3(3*ONE, 0, 0), '0, 8'h06);
    tick();
    chk_out("mul", v3(3*ONE, 32'hFFFA_0000, 32'hFFFF_0000), 1'b0, 1'b0, 8'h05);
    drive(OP_NEG, v3(32'h8000_0000, ONE, 0), '0, '0, 8'h07);
    tick();
    idle();
    chk_out("sub", v3(32'hFFFE_0000, ONE, ONE), 1'b0, 1'b0, 8'h06);
    tick();
    chk_out("neg_sat", v3(32'h7FFF_FFFF, 32'hFFFF_0000, 0), 1'b1, 1'b0, 8'h07);
    chk("neg_wrap.res", i0.out_res, v3(32'h8000_0000, 32'hFFFF_0000, 0));
    chk("neg_wrap.ovf", 96'(i0.out_ovf), 96'(1'b1));

    // 8 back-to-back ops
    for (int i = 0; i < 8; i++) begin
      drive(OP_ADD, v3(32'(i) << 16, 0, 0), v3(ONE, 0, 0), '0, 8'(i));
      tick();
      if (i > 0)
        chk_out("b2b", v3(32'(i) << 16, 0, 0), 1'b0, 1'b0, 8'(i - 1));
    end
    idle();
    tick();
    chk_out("b2b", v3(32'(8) << 16, 0, 0), 1'b0, 1'b0, 8'd7);
    tick();
    chk("b2b.drain", 96'(i1.out_valid), 96'(1'b0));

    // stall with out_ready=0 for 5 cycles
    k = 0;
    r = 0;
    nfire = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (k < 4)
        drive(OP_ADD, v3(32'(k) << 16, 0, 0), v3(2*ONE, 0, 0), '0, 8'(10 + k));
      else
        idle();
      set_ordy(cyc >= 5);
      #1;
      if (cyc == 2) begin
        chk("stall.in_ready", 96'(i1.in_ready), 96'(1'b0));
        chk("stall.accepted", 96'(k), 96'(2));
      end
      acc  = i1.in_valid && i1.in_ready;
      fire = i1.out_valid && i1.out_ready;
      if (i1.out_valid && !i1.out_ready)
        chk("stall.hold", {i1.out_res[31:0], 24'(i1.out_tag)},
            {32'(r + 2) << 16, 24'(10 + r)});
      if (fire) begin
        if (r < 4)
          chk_out("stall", v3(32'(r + 2) << 16, 0, 0), 1'b0, 1'b0, 8'(10 + r));
        r++;
        nfire++;
      end
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    chk("stall.fired", 96'(nfire), 96'(4));
    chk("stall.sent", 96'(k), 96'(4));

    // reset with two ops in flight
    set_ordy(1'b1);
    drive(OP_ADD, v3(ONE, 0, 0), v3(ONE, 0, 0), '0, 8'd20);
    tick();
    drive(OP_ADD, v3(ONE, 0, 0), v3(ONE, 0, 0), '0, 8'd21);
    tick();
    idle();
    chk("pre_rst.valid", 96'(i1.out_valid), 96'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid", 96'(i1.out_valid), 96'(1'b0));
    chk("mid_rst.res", i1.out_res, '0);
    chk("mid_rst.tag", 96'(i1.out_tag), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst.in_ready", 96'(i1.in_ready), 96'(1'b1));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst.stale", 96'(i1.out_valid), 96'(1'b0));
    end

    // reserved opcode
    drive(OP_RSVD, v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), ONE, 8'h33);
    tick();
    idle();
    tick();
    chk_out("rsvd", '0, 1'b0, 1'b1, 8'h33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
